dcache_l1_wb: RTL and testbench
===============================

Name: dcache_l1_wb

Overview:
- Parametrised direct-mapped level-1 data cache sitting between the MIPS datapath's MEM stage and the next memory level.
- Generalised in line count, words per line and widths; adds a write-back policy with per-line dirty bits.
- Adds a refill/writeback FSM with a req/ack memory handshake, replacing the untimed line-install path.
- Miss behaviour is kept: data returns NOP_WORD, and the CPU re-issues the access until hit=1.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, CPU word width; must be 32 (byte enables are 4 bits).
- WORDS_PER_LINE, 4, words per line; power of 2, ≥2.
- NUM_LINES, 8, number of lines; power of 2, ≥2.
- NOP_WORD, 32'h0800_0000, value driven on data after a miss (control unit decodes it as no-op).
- Derived: OFF_W = log2(WORDS_PER_LINE) + 2; IDX_W = log2(NUM_LINES); TAG_W = ADDR_W − IDX_W − OFF_W; LINE_W = DATA_W × WORDS_PER_LINE.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- address  in  ADDR_W  CPU byte address; bits [1:0] ignored.
- inputData  in  DATA_W  CPU store data.
- byteEn  in  4  store byte enables; bit i covers byte i.
- readMem  in  1  load request.
- writeMem  in  1  store request.
- data  out  DATA_W  load result, registered.
- hit  out  1  registered; 1 = access sampled at the last edge completed.
- busy  out  1  registered; 1 = FSM not IDLE, so requests are ignored.
- memReq  out  1  memory request, held until memAck.
- memWe  out  1  1 = line write (writeback), 0 = line read (refill).
- memAddr  out  ADDR_W  line-aligned address (offset bits zero).
- memWData  out  LINE_W  victim line data.
- memRData  in  LINE_W  refill data, valid with memAck.
- memAck  in  1  one-cycle completion pulse.

Behaviour:
- Address split: tag = address[ADDR_W-1 : IDX_W+OFF_W]; idx = next IDX_W bits; word = address[OFF_W-1:2].
- Per-line state: valid, dirty, tag, LINE_W data.
- Reset (async, Rst_n low):
  - all valid and dirty bits 0;
  - data = 0, hit = 0, busy = 0, memReq = 0, memWe = 0, memAddr = 0, memWData = 0;
  - FSM goes to IDLE;
  - line data/tag contents are don't-care;
  - reset mid-transaction abandons it and drops memReq immediately, with no partial line install.
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE, at a rising edge with (readMem | writeMem), lookup hit = valid[idx] && tag match:
  - read hit: data <= word, hit <= 1.
  - write hit: enabled bytes of word updated, dirty[idx] <= 1, hit <= 1.
  - both readMem and writeMem asserted: data returns the pre-write word, then the write applies.
  - miss: hit <= 0, data <= NOP_WORD, busy <= 1, and the missing line address is latched.
    - If valid && dirty: memReq <= 1, memWe <= 1, memAddr <= {stored tag, idx, 0}, memWData <= line; go to WRITEBACK.
    - Otherwise: memReq <= 1, memWe <= 0, memAddr <= {tag, idx, 0}; go to REFILL.
- IDLE with no request: hit <= 0, data holds.
- WRITEBACK: on memAck, dirty <= 0, memWe <= 0, memAddr <= latched refill address, memReq stays 1; go to REFILL.
- REFILL: on memAck, line <= memRData, tag <= latched tag, valid <= 1, dirty <= 0, memReq <= 0, busy <= 0; go to IDLE.
- Latency:
  - hit: result visible one cycle after the sampling edge.
  - clean miss: the re-issued access hits no earlier than 1 cycle after memAck.
- While busy: readMem/writeMem are ignored, hit stays 0, data stays NOP_WORD.
- No write-allocate distinction: a store miss refills the line, and the re-issued store then hits.
- memAck while memReq = 0 is ignored.
- memAddr and memWData are stable while memReq = 1.

Decomposition:
- Shared package `cache_pkg` holds:
  - FSM state enum (IDLE/WRITEBACK/REFILL);
  - NOP_WORD default;
  - clog2-derived width constants and tag/idx/word extraction functions.
- One sub-module, `cache_line_array`: the valid/dirty/tag/data storage with a read port, a byte-enabled word-write port and a full-line write port. It is reused by the planned instruction cache.

Test Plan:
- Reset then read 0x0000_0040: hit = 0, data = 0x0800_0000, busy = 1, memReq = 1, memWe = 0, memAddr = 0x40. Ack with memRData word1 = 0xDEAD_BEEF and re-issue read of 0x44: hit = 1, data = 0xDEAD_BEEF.
- Write hit at 0x44 with byteEn = 4'b0011, inputData = 0x1234_5678, then read 0x44: data = 0xDEAD_5678, and that line's dirty bit is 1.
- Read 0x0000_00C4 (same idx 4, different tag): FSM goes to WRITEBACK with memWe = 1, memAddr = 0x40, memWData word1 = 0xDEAD_5678. After ack it goes to REFILL with memAddr = 0xC0. After the second ack the re-issued read hits.
- While busy, pulse writeMem to 0x80: no cache change and hit stays 0. A later read of 0x80 misses (memReq asserted).
- Assert Rst_n low during REFILL before memAck: memReq drops within the same cycle, all lines invalid, and a read of 0x40 misses again.
- readMem and writeMem together on a hit, inputData = 0xAAAA_AAAA, byteEn = 4'hF: data = old word, and a subsequent read returns 0xAAAA_AAAA.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache definitions: controller states, the no-op word, and address-field helpers
// sized for any address width up to AddrMaxW.
package cache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StRefill
  } cache_state_e;

  localparam logic [31:0] NopWord = 32'h0800_0000;
  localparam int unsigned AddrMaxW = 64;

  function automatic int unsigned off_width(input int unsigned words_per_line);
    return $clog2(words_per_line) + 2;
  endfunction

  function automatic logic [AddrMaxW-1:0] field_mask(input int unsigned width);
    return (AddrMaxW'(1) << width) - AddrMaxW'(1);
  endfunction

  function automatic logic [AddrMaxW-1:0] addr_tag(input logic [AddrMaxW-1:0] addr,
                                                   input int unsigned idx_w,
                                                   input int unsigned off_w);
    return addr >> (idx_w + off_w);
  endfunction

  function automatic logic [AddrMaxW-1:0] addr_idx(input logic [AddrMaxW-1:0] addr,
                                                   input int unsigned idx_w,
                                                   input int unsigned off_w);
    return (addr >> off_w) & field_mask(idx_w);
  endfunction

  function automatic logic [AddrMaxW-1:0] addr_word(input logic [AddrMaxW-1:0] addr,
                                                    input int unsigned off_w);
    return (addr >> 2) & field_mask(off_w - 2);
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line storage: valid/dirty flags (reset) plus tag and data arrays (no reset).
// One combinational read port, a byte-enabled word write and a full-line install.
module cache_line_array #(
  parameter int unsigned NumLines     = 8,
  parameter int unsigned WordsPerLine = 4,
  parameter int unsigned DataW        = 32,
  parameter int unsigned TagW         = 25,
  localparam int unsigned IdxW        = $clog2(NumLines),
  localparam int unsigned WordW       = $clog2(WordsPerLine),
  localparam int unsigned LineW       = DataW * WordsPerLine
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IdxW-1:0]   rd_idx_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TagW-1:0]   rd_tag_o,
  output logic [LineW-1:0]  rd_line_o,
  input  logic [IdxW-1:0]   wr_idx_i,
  input  logic              word_we_i,
  input  logic [WordW-1:0]  word_sel_i,
  input  logic [DataW/8-1:0] word_be_i,
  input  logic [DataW-1:0]  word_data_i,
  input  logic              line_we_i,
  input  logic [TagW-1:0]   line_tag_i,
  input  logic [LineW-1:0]  line_data_i,
  input  logic              clr_dirty_i
);

  typedef logic [WordsPerLine-1:0][DataW/8-1:0][7:0] line_t;

  logic [NumLines-1:0] valid_q;
  logic [NumLines-1:0] dirty_q;
  logic [TagW-1:0]     tag_q  [NumLines];
  line_t               data_q [NumLines];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end else if (clr_dirty_i) begin
      dirty_q[wr_idx_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[wr_idx_i]  <= line_tag_i;
      data_q[wr_idx_i] <= line_data_i;
    end else if (word_we_i) begin
      for (int b = 0; b < DataW / 8; b++) begin
        if (word_be_i[b]) begin
          data_q[wr_idx_i][word_sel_i][b] <= word_data_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_l1_wb.sv
// Direct-mapped write-back L1 data cache. Misses return the no-op word and run a
// writeback/refill sequence over a req/ack line interface; the CPU re-issues until hit.
module dcache_l1_wb
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned NUM_LINES      = 8,
  parameter logic [31:0] NOP_WORD       = NopWord,
  localparam int unsigned LINE_W        = DATA_W * WORDS_PER_LINE
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] inputData,
  input  logic [3:0]        byteEn,
  input  logic              readMem,
  input  logic              writeMem,
  output logic [DATA_W-1:0] data,
  output logic              hit,
  output logic              busy,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [LINE_W-1:0] memWData,
  input  logic [LINE_W-1:0] memRData,
  input  logic              memAck
);

  localparam int unsigned OFF_W  = off_width(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WORD_W = OFF_W - 2;

  cache_state_e      state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              hit_q, hit_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] refill_addr_q, refill_addr_d;

  logic [AddrMaxW-1:0] addr_ext;
  logic [TAG_W-1:0]    req_tag, ref_tag, rd_tag;
  logic [IDX_W-1:0]    req_idx, ref_idx, wr_idx;
  logic [WORD_W-1:0]   req_word;
  logic [ADDR_W-1:0]   line_addr, victim_addr;
  logic [LINE_W-1:0]   rd_line;
  logic [DATA_W-1:0]   rd_word;
  logic                rd_valid, rd_dirty, lookup_hit;
  logic                word_we, line_we, clr_dirty;

  assign addr_ext = AddrMaxW'(address);
  assign req_tag  = TAG_W'(addr_tag(addr_ext, IDX_W, OFF_W));
  assign req_idx  = IDX_W'(addr_idx(addr_ext, IDX_W, OFF_W));
  assign req_word = WORD_W'(addr_word(addr_ext, OFF_W));

  assign ref_tag = refill_addr_q[ADDR_W-1 -: TAG_W];
  assign ref_idx = refill_addr_q[OFF_W +: IDX_W];
  // Lookups only happen in idle; the other states touch the line being replaced.
  assign wr_idx  = (state_q == StIdle) ? req_idx : ref_idx;

  assign line_addr   = {address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign victim_addr = {rd_tag, req_idx, {OFF_W{1'b0}}};
  assign rd_word     = rd_line[req_word*DATA_W +: DATA_W];
  assign lookup_hit  = rd_valid && (rd_tag == req_tag);

  cache_line_array #(
    .NumLines    (NUM_LINES),
    .WordsPerLine(WORDS_PER_LINE),
    .DataW       (DATA_W),
    .TagW        (TAG_W)
  ) u_lines (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_idx_i   (wr_idx),
    .word_we_i  (word_we),
    .word_sel_i (req_word),
    .word_be_i  (byteEn),
    .word_data_i(inputData),
    .line_we_i  (line_we),
    .line_tag_i (ref_tag),
    .line_data_i(memRData),
    .clr_dirty_i(clr_dirty)
  );

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    hit_d         = 1'b0;
    busy_d        = busy_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    refill_addr_d = refill_addr_q;
    word_we       = 1'b0;
    line_we       = 1'b0;
    clr_dirty     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (readMem || writeMem) begin
          if (lookup_hit) begin
            hit_d = 1'b1;
            // A combined access returns the word as it was before this edge's write.
            if (readMem) data_d = rd_word;
            word_we = writeMem;
          end else begin
            data_d        = NOP_WORD;
            busy_d        = 1'b1;
            req_d         = 1'b1;
            refill_addr_d = line_addr;
            if (rd_valid && rd_dirty) begin
              we_d    = 1'b1;
              addr_d  = victim_addr;
              wdata_d = rd_line;
              state_d = StWriteback;
            end else begin
              we_d    = 1'b0;
              addr_d  = line_addr;
              state_d = StRefill;
            end
          end
        end
      end
      StWriteback: begin
        if (memAck) begin
          clr_dirty = 1'b1;
          we_d      = 1'b0;
          addr_d    = refill_addr_q;
          state_d   = StRefill;
        end
      end
      StRefill: begin
        if (memAck) begin
          line_we = 1'b1;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= StIdle;
      data_q        <= '0;
      hit_q         <= 1'b0;
      busy_q        <= 1'b0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      refill_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      hit_q         <= hit_d;
      busy_q        <= busy_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      refill_addr_q <= refill_addr_d;
    end
  end

  assign data     = data_q;
  assign hit      = hit_q;
  assign busy     = busy_q;
  assign memReq   = req_q;
  assign memWe    = we_q;
  assign memAddr  = addr_q;
  assign memWData = wdata_q;

endmodule

// File: tb/tb_dcache_l1_wb.sv
// Randomised bench for dcache_l1_wb: a line-level cache model plus a backing memory
// predict every hit, miss, writeback and returned word.
module tb_dcache_l1_wb;

  localparam logic [31:0] Nop = 32'h0800_0000;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic [31:0]  address = '0;
  logic [31:0]  inputData = '0;
  logic [3:0]   byteEn = '0;
  logic         readMem = 1'b0;
  logic         writeMem = 1'b0;
  logic [31:0]  data;
  logic         hit, busy, memReq, memWe;
  logic [31:0]  memAddr;
  logic [127:0] memWData;
  logic [127:0] memRData = '0;
  logic         memAck = 1'b0;

  always #5 Clk = ~Clk;

  dcache_l1_wb dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .address (address),
    .inputData(inputData),
    .byteEn  (byteEn),
    .readMem (readMem),
    .writeMem(writeMem),
    .data    (data),
    .hit     (hit),
    .busy    (busy),
    .memReq  (memReq),
    .memWe   (memWe),
    .memAddr (memAddr),
    .memWData(memWData),
    .memRData(memRData),
    .memAck  (memAck)
  );

  // Reference state
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];
  logic [127:0] m_line  [8];
  logic [127:0] mem     [bit [31:0]];
  logic [31:0]  last_data;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    last_data = '0;
  endtask

  task automatic get_line(input logic [31:0] la, output logic [127:0] line);
    if (!mem.exists(la)) mem[la] = {$urandom, $urandom, $urandom, $urandom};
    line = mem[la];
  endtask

  task automatic idle_inputs();
    readMem  = 1'b0;
    writeMem = 1'b0;
  endtask

  // While the cache is busy, stray requests must be ignored.
  task automatic mem_wait(input int n, input logic [31:0] exp_addr);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check_eq("req_held", memReq, 1'b1);
      check_eq("addr_stable", memAddr, exp_addr);
      check_eq("busy_hit", hit, 1'b0);
      check_eq("busy_data", data, Nop);
      readMem   = 1'($urandom);
      writeMem  = 1'($urandom);
      address   = $urandom & 32'h1FC;
      inputData = $urandom;
      byteEn    = 4'($urandom);
    end
  endtask

  // Caller is at a negedge; returns at a negedge with the observed data.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] got);
    int unsigned idx, word;
    logic [24:0]  tag;
    logic [31:0]  la, victim, exp_data;
    logic [127:0] line;
    idx  = (a >> 4) & 7;
    word = (a >> 2) & 3;
    tag  = 25'(a >> 7);
    la   = a & ~32'hF;
    address = a; inputData = wd; byteEn = be; readMem = rd; writeMem = wr;
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      @(negedge Clk);
      check_eq("miss_hit", hit, 1'b0);
      check_eq("miss_data", data, Nop);
      check_eq("miss_busy", busy, 1'b1);
      check_eq("miss_req", memReq, 1'b1);
      if (m_valid[idx] && m_dirty[idx]) begin
        victim = (32'(m_tag[idx]) << 7) | (idx << 4);
        check_eq("wb_we", memWe, 1'b1);
        check_eq("wb_addr", memAddr, victim);
        check_eq("wb_wdata", memWData, m_line[idx]);
        mem_wait($urandom_range(0, 3), victim);
        idle_inputs();
        memAck = 1'b1;
        @(negedge Clk);
        memAck = 1'b0;
        mem[victim] = m_line[idx];
        m_dirty[idx] = 1'b0;
        check_eq("rf_req", memReq, 1'b1);
        check_eq("rf_we", memWe, 1'b0);
        check_eq("rf_addr", memAddr, la);
      end else begin
        check_eq("rf_we", memWe, 1'b0);
        check_eq("rf_addr", memAddr, la);
      end
      mem_wait($urandom_range(0, 3), la);
      idle_inputs();
      get_line(la, line);
      memRData = line;
      memAck = 1'b1;
      @(negedge Clk);
      memAck = 1'b0;
      memRData = {$urandom, $urandom, $urandom, $urandom};
      check_eq("done_req", memReq, 1'b0);
      check_eq("done_busy", busy, 1'b0);
      check_eq("done_hit", hit, 1'b0);
      check_eq("done_data", data, Nop);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
      m_line[idx]  = line;
      last_data    = Nop;
      address = a; inputData = wd; byteEn = be; readMem = rd; writeMem = wr;
    end
    @(negedge Clk);
    idle_inputs();
    got = data;
    line = m_line[idx];
    exp_data = rd ? line[word*32 +: 32] : last_data;
    check_eq("hit", hit, 1'b1);
    check_eq("hit_data", data, exp_data);
    check_eq("hit_req", memReq, 1'b0);
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) line[word*32 + b*8 +: 8] = wd[b*8 +: 8];
      m_line[idx]  = line;
      m_dirty[idx] = 1'b1;
    end
    last_data = exp_data;
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int op;
    model_reset();
    repeat (2) @(negedge Clk);
    check_eq("rst_data", data, 32'h0);
    check_eq("rst_hit", hit, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_req", memReq, 1'b0);
    check_eq("rst_we", memWe, 1'b0);
    check_eq("rst_addr", memAddr, 32'h0);
    check_eq("rst_wdata", memWData, 128'h0);
    Rst_n = 1'b1;

    mem[32'h40] = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};

    // Miss on 0x40, then reset in the middle of the refill.
    address = 32'h40; readMem = 1'b1;
    @(negedge Clk);
    readMem = 1'b0;
    check_eq("m40_hit", hit, 1'b0);
    check_eq("m40_data", data, Nop);
    check_eq("m40_busy", busy, 1'b1);
    check_eq("m40_req", memReq, 1'b1);
    check_eq("m40_we", memWe, 1'b0);
    check_eq("m40_addr", memAddr, 32'h40);
    @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    check_eq("arst_req", memReq, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_data", data, 32'h0);
    check_eq("arst_addr", memAddr, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();

    access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, got);
    access(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, got);
    check_eq("tp_read44", got, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'h44, 32'h1234_5678, 4'b0011, got);
    access(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, got);
    check_eq("tp_merge44", got, 32'hDEAD_5678);
    access(1'b1, 1'b0, 32'hC4, 32'h0, 4'h0, got);
    access(1'b1, 1'b1, 32'hC4, 32'hAAAA_AAAA, 4'hF, got);
    access(1'b1, 1'b0, 32'hC4, 32'h0, 4'h0, got);
    check_eq("tp_rw_after", got, 32'hAAAA_AAAA);
    access(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, got);

    for (int n = 0; n < 300; n++) begin
      a  = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
      op = $urandom_range(0, 3);
      if (op == 3) begin
        @(negedge Clk);
        check_eq("idle_hit", hit, 1'b0);
        check_eq("idle_data", data, last_data);
      end else begin
        access(op != 1, op != 0, a, $urandom, 4'($urandom), got);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
